matmul_ctrl: RTL and testbench



---
 rtl/matmul_ctrl.sv | 158 +++++++++++++++
 tb/tb_matmul_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_ctrl.sv
// Matrix-multiply sequencer: reads P/Q/R header, A and B from data memory,
// multiply-accumulates each element of C and writes it back in place.
module matmul_ctrl #(
    parameter int DW  = 16,
    parameter int AW  = 8,
    parameter int HDR = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_addr0,
    output logic          mem_we0,
    output logic [DW-1:0] mem_wdata0,
    input  logic [DW-1:0] mem_rdata0,
    output logic [AW-1:0] mem_addr1,
    output logic          mem_we1,
    input  logic [DW-1:0] mem_rdata1
);

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, CHK, MAC, LAST, WR, FIN
    } state_t;

    state_t        state;
    logic [AW-1:0] p, q, r, i, j, k, bb, bc;
    logic [DW-1:0] acc, prod;
    logic [AW-1:0] r_in, k1, ni, nj;
    logic [AW-1:0] mac_a, mac_b, row_a, row_b, wr_c;
    logic [16:0]   bb_c, bc_c;
    logic [17:0]   end_c;
    logic          bad, last_k, last_j, last_el;

    // Header and bounds math; the end check gets an extra bit so that
    // huge headers cannot wrap back into the legal range.
    assign r_in  = mem_rdata0[AW-1:0];
    assign bb_c  = 17'(HDR) + 17'(p) * 17'(q);
    assign bc_c  = bb_c + 17'(q) * 17'(r_in);
    assign end_c = 18'(bc_c) + 18'(p) * 18'(r_in);
    assign bad   = (p == '0) || (q == '0) || (r_in == '0)
                || (end_c > 18'd256);

    assign prod    = DW'(mem_rdata0 * mem_rdata1);
    assign k1      = k + AW'(1);
    assign last_k  = (k == q - AW'(1));
    assign last_j  = (j == r - AW'(1));
    assign last_el = last_j && (i == p - AW'(1));
    assign nj      = last_j ? '0 : j + AW'(1);
    assign ni      = last_j ? i + AW'(1) : i;

    // All addresses are in range once the bounds check passed.
    assign mac_a = AW'(HDR) + i * q + k1;
    assign mac_b = bb + k1 * r + j;
    assign row_a = AW'(HDR) + ni * q;
    assign row_b = bb + nj;
    assign wr_c  = bc + i * r + j;

    assign mem_we1 = 1'b0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_addr0  <= '0;
            mem_addr1  <= '0;
            mem_we0    <= 1'b0;
            mem_wdata0 <= '0;
            p          <= '0;
            q          <= '0;
            r          <= '0;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            bb         <= '0;
            bc         <= '0;
            acc        <= '0;
        end else begin
            done    <= 1'b0;
            mem_we0 <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= HDR0;
                    busy      <= 1'b1;
                    err       <= 1'b0;
                    mem_addr0 <= '0;
                    mem_addr1 <= AW'(1);
                end
                HDR0: begin
                    state     <= HDR1;
                    mem_addr0 <= AW'(2);
                end
                HDR1: begin
                    state <= CHK;
                    p     <= mem_rdata0[AW-1:0];
                    q     <= mem_rdata1[AW-1:0];
                end
                CHK: begin
                    r  <= r_in;
                    bb <= AW'(bb_c);
                    bc <= AW'(bc_c);
                    if (bad) begin
                        state <= FIN;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= MAC;
                        i         <= '0;
                        j         <= '0;
                        k         <= '0;
                        acc       <= '0;
                        mem_addr0 <= AW'(HDR);
                        mem_addr1 <= AW'(bb_c);
                    end
                end
                MAC: begin
                    if (k != '0)
                        acc <= acc + prod;
                    if (last_k) begin
                        state <= LAST;
                    end else begin
                        k         <= k1;
                        mem_addr0 <= mac_a;
                        mem_addr1 <= mac_b;
                    end
                end
                LAST: begin
                    state      <= WR;
                    mem_we0    <= 1'b1;
                    mem_addr0  <= wr_c;
                    mem_wdata0 <= acc + prod;
                end
                WR: begin
                    acc <= '0;
                    k   <= '0;
                    i   <= ni;
                    j   <= nj;
                    if (last_el) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= MAC;
                        mem_addr0 <= row_a;
                        mem_addr1 <= row_b;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Scoreboard bench for matmul_ctrl with a registered-read memory model;
// expected writes and done events are queued and checked by a monitor.
module tb_matmul_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [7:0]  mem_addr0, mem_addr1;
    logic        mem_we0, mem_we1;
    logic [15:0] mem_wdata0, mem_rdata0, mem_rdata1;

    logic [15:0] ram [256];

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct packed {
        logic        e;
        logic [15:0] c;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    int errors = 0;
    int checks = 0;
    int cnt = 0;

    always #5 clock = ~clock;

    matmul_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_addr0  (mem_addr0),
        .mem_we0    (mem_we0),
        .mem_wdata0 (mem_wdata0),
        .mem_rdata0 (mem_rdata0),
        .mem_addr1  (mem_addr1),
        .mem_we1    (mem_we1),
        .mem_rdata1 (mem_rdata1)
    );

    always @(posedge clock) begin
        mem_rdata0 <= ram[mem_addr0];
        mem_rdata1 <= ram[mem_addr1];
        if (mem_we0)
            ram[mem_addr0] <= mem_wdata0;
    end

    function automatic void chk(input string name, input int act,
                                input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT writes or signals done.
    always @(negedge clock) begin
        wr_t w;
        dn_t d;
        if (mem_we0 === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexp addr=%0d data=%0d expected none",
                         mem_addr0, mem_wdata0);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", int'(mem_addr0), int'(w.a));
                chk("wr_data", int'(mem_wdata0), int'(w.d));
            end
        end
        if (busy === 1'b1 || done === 1'b1) cnt++;
        else cnt = 0;
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexp err=%0d expected no done", err);
            end else begin
                d = dq.pop_front();
                chk("done_err", int'(err), int'(d.e));
                chk("done_cycles", cnt, int'(d.c));
            end
        end
    end

    task automatic push_wr(input int a, input int d);
        wr_t w;
        w.a = 8'(a);
        w.d = 16'(d);
        wq.push_back(w);
    endtask

    task automatic push_done(input int e, input int c);
        dn_t d;
        d.e = 1'(e);
        d.c = 16'(c);
        dq.push_back(d);
    endtask

    task automatic load_hdr(input int p, input int q, input int r);
        foreach (ram[a]) ram[a] = '0;
        ram[0] = 16'(p);
        ram[1] = 16'(q);
        ram[2] = 16'(r);
    endtask

    task automatic load_default();
        load_hdr(2, 4, 2);
        for (int n = 0; n < 16; n++) ram[3 + n] = 16'(n + 1);
    endtask

    // Pulse start, optionally poke start again mid-run, wait for done.
    task automatic run(input string name, input int limit, input int poke);
        bit seen = 0;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clock);
            start = (n == poke);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_done expected=done", name);
        end
        repeat (3) @(negedge clock);
        chk({name, "_wq_left"}, wq.size(), 0);
        chk({name, "_dq_left"}, dq.size(), 0);
    endtask

    initial begin
        bit seen;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_outs", int'({busy, done, err, mem_we0, mem_we1}), 0);
        chk("rst_addr", int'({mem_addr0, mem_addr1}), 0);
        chk("rst_wdata", int'(mem_wdata0), 0);
        @(negedge clock) reset_n = 1'b1;

        // default 2x4 * 4x2 with a stray start while busy
        load_default();
        push_wr(19, 130);
        push_wr(20, 140);
        push_wr(21, 322);
        push_wr(22, 348);
        push_done(0, 28);
        run("default", 60, 6);
        chk("ram19", int'(ram[19]), 130);
        chk("ram22", int'(ram[22]), 348);
        chk("idle_busy", int'(busy), 0);

        // 1x1x1
        load_hdr(1, 1, 1);
        ram[3] = 16'd7;
        ram[4] = 16'd9;
        push_wr(5, 63);
        push_done(0, 7);
        run("one", 30, -1);
        chk("ram5", int'(ram[5]), 63);

        // Q = 0 rejected
        load_hdr(2, 0, 2);
        push_done(1, 4);
        run("q0", 30, -1);

        // oversized header rejected
        load_hdr(10, 10, 10);
        push_done(1, 4);
        run("big", 30, -1);

        // product wraps modulo 2^16
        load_hdr(1, 1, 1);
        ram[3] = 16'd300;
        ram[4] = 16'd300;
        push_wr(5, 24464);
        push_done(0, 7);
        run("wrap", 30, -1);

        // C ends exactly at address 255
        load_hdr(1, 1, 126);
        ram[3] = 16'd2;
        for (int n = 0; n < 126; n++) begin
            ram[4 + n] = 16'(n + 1);
            push_wr(130 + n, 2 * (n + 1));
        end
        push_done(0, 382);
        run("edge256", 500, -1);
        chk("ram255", int'(ram[255]), 252);

        // one past the end is rejected
        load_hdr(1, 2, 84);
        push_done(1, 4);
        run("edge257", 30, -1);

        // reset during MAC of the second element
        load_default();
        push_wr(19, 130);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (mem_we0 === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL rst_run timeout actual=no_write expected=write");
        end
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_rst_outs", int'({busy, done, err, mem_we0, mem_we1}), 0);
        chk("mid_rst_addr", int'({mem_addr0, mem_addr1}), 0);
        chk("mid_rst_wdata", int'(mem_wdata0), 0);
        @(negedge clock) reset_n = 1'b1;
        repeat (40) @(negedge clock);
        chk("mid_rst_wq", wq.size(), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ram20", int'(ram[20]), 0);

        // normal run after reset
        load_default();
        push_wr(19, 130);
        push_wr(20, 140);
        push_wr(21, 322);
        push_wr(22, 348);
        push_done(0, 28);
        run("after_rst", 60, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
